hpdcache_csr_perf: RTL and testbench

Register-mapped configuration and performance-monitor block on the software side of the HPDcache configuration/event interface. It drives all cfg_* inputs of the cache from CSRs written over a simple valid/ready register port. It also counts the cache's evt_* pulses in per-event counters that software can read, preload, freeze and clear. It sits between a core CSR/MMIO bus adapter and the HPDcache top.

---
 rtl/hpdcache_csr_perf_pkg.sv | 46 ++++
 rtl/hpdcache_csr_perf_cnt.sv | 34 +++
 rtl/hpdcache_csr_perf.sv | 172 +++++++++++++++++
 tb/tb_hpdcache_csr_perf.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_csr_perf_pkg.sv
// Shared definitions for the HPDcache CSR/performance-monitor block:
// register map, event indices, CFG0 bit layout and handshake FSM states.
package hpdcache_csr_perf_pkg;

  localparam logic [3:0] CSR_CFG0 = 4'h0;
  localparam logic [3:0] CSR_CFG1 = 4'h1;
  localparam logic [3:0] CSR_CTRL = 4'h2;
  localparam logic [3:0] CSR_OVF  = 4'h3;
  localparam logic [3:0] CSR_CNT0 = 4'h4;
  localparam logic [3:0] CSR_CNT1 = 4'h5;
  localparam logic [3:0] CSR_CNT2 = 4'h6;
  localparam logic [3:0] CSR_CNT3 = 4'h7;
  localparam logic [3:0] CSR_CNT4 = 4'h8;
  localparam logic [3:0] CSR_CNT5 = 4'h9;
  localparam logic [3:0] CSR_CNT6 = 4'hA;
  localparam logic [3:0] CSR_CNT7 = 4'hB;

  typedef enum logic [2:0] {
    EVT_CACHE_WRITE_MISS,
    EVT_CACHE_READ_MISS,
    EVT_UNCACHED_REQ,
    EVT_CMO_REQ,
    EVT_WRITE_REQ,
    EVT_READ_REQ,
    EVT_GRANTED_REQ,
    EVT_REQ_ON_HOLD
  } evt_idx_e;

  localparam int unsigned CFG0_ENABLE                = 0;
  localparam int unsigned CFG0_RESET_TIMECNT_ON_WRITE = 1;
  localparam int unsigned CFG0_SEQUENTIAL_WAW        = 2;
  localparam int unsigned CFG0_INHIBIT_WRITE_COALESC = 3;
  localparam int unsigned CFG0_HWPF_STRIDE_UPDT_PLRU = 4;
  localparam int unsigned CFG0_ERROR_ON_CACHEABLE_AMO = 5;
  localparam int unsigned CFG0_RTAB_SINGLE_ENTRY     = 6;
  localparam int unsigned CFG0_DEFAULT_WB            = 7;

  localparam int unsigned CFG1_SID_LSB = 16;
  localparam int unsigned CTRL_FREEZE  = 0;
  localparam int unsigned CTRL_CLEAR   = 1;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RESP = 1'b1;

endpackage

// File: rtl/hpdcache_csr_perf_cnt.sv
// Single event counter: clear beats load, load beats increment; wrap flags
// the increment that rolls over from all-ones to zero.
module hpdcache_csr_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  input  logic             freeze,
  output logic [CNT_W-1:0] value,
  output logic             wrap
);

  logic step;

  assign step = inc && !freeze && !load && !clear;
  assign wrap = step && (value == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/hpdcache_csr_perf.sv
// CSR front-end for the HPDcache: drives the cfg_* controls from registers
// and counts evt_* pulses in eight software-visible counters.
module hpdcache_csr_perf
  import hpdcache_csr_perf_pkg::*;
#(
  parameter int unsigned               CNT_W              = 32,
  parameter int unsigned               WBUF_TIMECNT_W     = 3,
  parameter int unsigned               SID_W              = 3,
  parameter logic [WBUF_TIMECNT_W-1:0] RST_WBUF_THRESHOLD = 3,
  parameter logic                      RST_ENABLE         = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      csr_req_valid_i,
  output logic                      csr_req_ready_o,
  input  logic                      csr_req_we_i,
  input  logic [3:0]                csr_req_addr_i,
  input  logic [31:0]               csr_req_wdata_i,
  output logic                      csr_rsp_valid_o,
  input  logic                      csr_rsp_ready_i,
  output logic [31:0]               csr_rsp_rdata_o,
  output logic                      csr_rsp_err_o,
  input  logic [7:0]                evt_i,
  output logic                      cfg_enable_o,
  output logic [WBUF_TIMECNT_W-1:0] cfg_wbuf_threshold_o,
  output logic                      cfg_wbuf_reset_timecnt_on_write_o,
  output logic                      cfg_wbuf_sequential_waw_o,
  output logic                      cfg_wbuf_inhibit_write_coalescing_o,
  output logic                      cfg_hwpf_stride_updt_plru_o,
  output logic [SID_W-1:0]          cfg_hwpf_stride_sid_o,
  output logic                      cfg_error_on_cacheable_amo_o,
  output logic                      cfg_rtab_single_entry_o,
  output logic                      cfg_default_wb_o
);

  localparam int unsigned NUM_EVT = int'(EVT_REQ_ON_HOLD) + 1;

  state_t                      state, state_next;
  logic                        accept, wr, unmapped, is_cnt, clear;
  logic                        wr_cfg0, wr_cfg1, wr_ctrl, wr_ovf;
  logic [7:0]                  cfg0_q;
  logic [WBUF_TIMECNT_W-1:0]   thr_q;
  logic [SID_W-1:0]            sid_q;
  logic                        freeze_q;
  logic [NUM_EVT-1:0]          ovf_q, wrap_vec;
  logic [CNT_W-1:0]            cnt_val [NUM_EVT];
  logic [2:0]                  cnt_idx;
  logic [31:0]                 rdata_mux;

  // In RESP a new request can only be taken while the response drains.
  assign csr_req_ready_o = (state == ST_IDLE) ? 1'b1 : csr_rsp_ready_i;
  assign csr_rsp_valid_o = (state == ST_RESP);

  assign accept   = csr_req_valid_i && csr_req_ready_o;
  assign wr       = accept && csr_req_we_i;
  assign unmapped = csr_req_addr_i > CSR_CNT7;
  assign is_cnt   = (csr_req_addr_i >= CSR_CNT0) && !unmapped;
  assign cnt_idx  = 3'(csr_req_addr_i - CSR_CNT0);

  assign wr_cfg0 = wr && (csr_req_addr_i == CSR_CFG0);
  assign wr_cfg1 = wr && (csr_req_addr_i == CSR_CFG1);
  assign wr_ctrl = wr && (csr_req_addr_i == CSR_CTRL);
  assign wr_ovf  = wr && (csr_req_addr_i == CSR_OVF);
  assign clear   = wr_ctrl && csr_req_wdata_i[CTRL_CLEAR];

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = ST_RESP;
    end else if (state == ST_RESP && csr_rsp_ready_i) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    rdata_mux = '0;
    if (is_cnt) begin
      rdata_mux[CNT_W-1:0] = cnt_val[cnt_idx];
    end else begin
      case (csr_req_addr_i)
        CSR_CFG0: rdata_mux[7:0] = cfg0_q;
        CSR_CFG1: begin
          rdata_mux[WBUF_TIMECNT_W-1:0]   = thr_q;
          rdata_mux[CFG1_SID_LSB +: SID_W] = sid_q;
        end
        CSR_CTRL: rdata_mux[CTRL_FREEZE] = freeze_q;
        CSR_OVF:  rdata_mux[NUM_EVT-1:0] = ovf_q;
        default:  rdata_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csr_rsp_rdata_o <= '0;
      csr_rsp_err_o   <= 1'b0;
    end else if (accept) begin
      csr_rsp_rdata_o <= csr_req_we_i ? '0 : rdata_mux;
      csr_rsp_err_o   <= unmapped;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg0_q              <= '0;
      cfg0_q[CFG0_ENABLE] <= RST_ENABLE;
      thr_q               <= RST_WBUF_THRESHOLD;
      sid_q               <= '0;
      freeze_q            <= 1'b0;
    end else begin
      if (wr_cfg0) begin
        cfg0_q <= csr_req_wdata_i[7:0];
      end
      if (wr_cfg1) begin
        thr_q <= csr_req_wdata_i[WBUF_TIMECNT_W-1:0];
        sid_q <= csr_req_wdata_i[CFG1_SID_LSB +: SID_W];
      end
      if (wr_ctrl) begin
        freeze_q <= csr_req_wdata_i[CTRL_FREEZE];
      end
    end
  end

  // A wrap in the same cycle as a W1C on that bit leaves the bit set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
    end else if (clear) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~(wr_ovf ? csr_req_wdata_i[NUM_EVT-1:0] : '0)) | wrap_vec;
    end
  end

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_cnt
    localparam logic [3:0] CNT_ADDR = CSR_CNT0 + 4'(k);

    hpdcache_csr_perf_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .inc      (evt_i[k]),
      .load     (wr && (csr_req_addr_i == CNT_ADDR)),
      .load_val (csr_req_wdata_i[CNT_W-1:0]),
      .clear    (clear),
      .freeze   (freeze_q),
      .value    (cnt_val[k]),
      .wrap     (wrap_vec[k])
    );
  end

  assign cfg_enable_o                        = cfg0_q[CFG0_ENABLE];
  assign cfg_wbuf_reset_timecnt_on_write_o   = cfg0_q[CFG0_RESET_TIMECNT_ON_WRITE];
  assign cfg_wbuf_sequential_waw_o           = cfg0_q[CFG0_SEQUENTIAL_WAW];
  assign cfg_wbuf_inhibit_write_coalescing_o = cfg0_q[CFG0_INHIBIT_WRITE_COALESC];
  assign cfg_hwpf_stride_updt_plru_o         = cfg0_q[CFG0_HWPF_STRIDE_UPDT_PLRU];
  assign cfg_error_on_cacheable_amo_o        = cfg0_q[CFG0_ERROR_ON_CACHEABLE_AMO];
  assign cfg_rtab_single_entry_o             = cfg0_q[CFG0_RTAB_SINGLE_ENTRY];
  assign cfg_default_wb_o                    = cfg0_q[CFG0_DEFAULT_WB];
  assign cfg_wbuf_threshold_o                = thr_q;
  assign cfg_hwpf_stride_sid_o               = sid_q;

endmodule

// File: tb/tb_hpdcache_csr_perf.sv
// Bench for hpdcache_csr_perf: register-map vector table, directed corner
// sequences and a randomized phase checked against a register-level model.
module tb_hpdcache_csr_perf;

  localparam int CNT_W = 32;
  localparam int WB_W  = 3;
  localparam int SID_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [3:0]        req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [7:0]        evt;
  logic              c_en, c_rtw, c_waw, c_inh, c_plru, c_amo, c_rtab, c_wb;
  logic [WB_W-1:0]   c_thr;
  logic [SID_W-1:0]  c_sid;

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  hpdcache_csr_perf #(
    .CNT_W(CNT_W), .WBUF_TIMECNT_W(WB_W), .SID_W(SID_W),
    .RST_WBUF_THRESHOLD(3'd3), .RST_ENABLE(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
    .csr_req_we_i(req_we), .csr_req_addr_i(req_addr), .csr_req_wdata_i(req_wdata),
    .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
    .csr_rsp_rdata_o(rsp_rdata), .csr_rsp_err_o(rsp_err),
    .evt_i(evt),
    .cfg_enable_o(c_en), .cfg_wbuf_threshold_o(c_thr),
    .cfg_wbuf_reset_timecnt_on_write_o(c_rtw), .cfg_wbuf_sequential_waw_o(c_waw),
    .cfg_wbuf_inhibit_write_coalescing_o(c_inh), .cfg_hwpf_stride_updt_plru_o(c_plru),
    .cfg_hwpf_stride_sid_o(c_sid), .cfg_error_on_cacheable_amo_o(c_amo),
    .cfg_rtab_single_entry_o(c_rtab), .cfg_default_wb_o(c_wb)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (register-level view) ----------------
  typedef struct packed {
    logic [7:0][CNT_W-1:0] cnt;
    logic [7:0]            ovf;
    logic [7:0]            cfg0;
    logic [WB_W-1:0]       thr;
    logic [SID_W-1:0]      sid;
    logic                  frz;
  } mstate_t;

  mstate_t     ms;
  logic        m_busy, m_err, m_acc;
  logic [31:0] m_rdata;

  function automatic mstate_t m_reset();
    mstate_t s = '0;
    s.cfg0 = 8'h01;
    s.thr  = 3'd3;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input mstate_t s, input logic [3:0] a);
    logic [31:0] r = '0;
    if (a == 4'h0) r[7:0] = s.cfg0;
    else if (a == 4'h1) begin r[WB_W-1:0] = s.thr; r[16 +: SID_W] = s.sid; end
    else if (a == 4'h2) r[0] = s.frz;
    else if (a == 4'h3) r[7:0] = s.ovf;
    else if (a >= 4'h4 && a <= 4'hB) r[CNT_W-1:0] = s.cnt[a - 4'h4];
    return r;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input logic acc, input logic we,
                                     input logic [3:0] a, input logic [31:0] d, input logic [7:0] ev);
    mstate_t n = s;
    logic wr = acc && we;
    if (wr && a == 4'h2 && d[1]) begin
      n.cnt = '0;
      n.ovf = '0;
      n.frz = d[0];
      return n;
    end
    if (wr && a == 4'h3) n.ovf = s.ovf & ~d[7:0];
    for (int k = 0; k < 8; k++) begin
      if (wr && a == 4'(4 + k)) n.cnt[k] = d[CNT_W-1:0];
      else if (!s.frz && ev[k]) begin
        n.cnt[k] = s.cnt[k] + 1'b1;
        if (n.cnt[k] == '0) n.ovf[k] = 1'b1;
      end
    end
    if (wr && a == 4'h0) n.cfg0 = d[7:0];
    if (wr && a == 4'h1) begin n.thr = d[WB_W-1:0]; n.sid = d[16 +: SID_W]; end
    if (wr && a == 4'h2) n.frz = d[0];
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms <= m_reset(); m_busy <= 1'b0; m_err <= 1'b0; m_rdata <= '0; m_acc <= 1'b0;
    end else begin
      m_acc <= req_valid && (!m_busy || rsp_ready);
      if (req_valid && (!m_busy || rsp_ready)) begin
        m_busy  <= 1'b1;
        m_rdata <= req_we ? 32'h0 : m_read(ms, req_addr);
        m_err   <= (req_addr > 4'hB);
      end else if (rsp_ready) begin
        m_busy <= 1'b0;
      end
      ms <= m_step(ms, req_valid && (!m_busy || rsp_ready), req_we, req_addr, req_wdata, evt);
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("mon_rsp_valid", 32'(rsp_valid), 32'(m_busy));
      check("mon_req_ready", 32'(req_ready), 32'(!m_busy || rsp_ready));
      if (m_busy) begin
        check("mon_rdata", rsp_rdata, m_rdata);
        check("mon_err", 32'(rsp_err), 32'(m_err));
      end
      check("mon_cfg", 32'({c_wb, c_rtab, c_amo, c_plru, c_inh, c_waw, c_rtw, c_en, c_thr, c_sid}),
            32'({ms.cfg0, ms.thr, ms.sid}));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [3:0] a, input logic [31:0] d,
                      input logic [7:0] ev, input int hold,
                      output logic [31:0] rd, output logic e);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; evt = ev;
    tick();
    req_valid = 1'b0; evt = 8'h00;
    check("rsp_latency", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    e  = rsp_err;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_req_ready", 32'(req_ready), 32'd0);
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold_rdata", rsp_rdata, rd);
      end
      rsp_ready = 1'b1;
    end
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    xfer(1'b0, a, 32'h0, 8'h00, 0, rd, e);
    check(name, rd, exp);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d, input logic [7:0] ev);
    logic [31:0] rd;
    logic        e;
    xfer(1'b1, a, d, ev, 0, rd, e);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] rd;
  logic        e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0001, 1'b0};
    vecs[1]  = '{1'b0, 4'h1, 32'h0,         32'h0000_0003, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 32'h0000_00FE, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 4'h1, 32'h0005_0007, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,         32'h0000_00FE, 1'b0};
    vecs[5]  = '{1'b0, 4'h1, 32'h0,         32'h0005_0007, 1'b0};
    vecs[6]  = '{1'b1, 4'h1, 32'hFFFF_FFFA, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 4'h1, 32'h0,         32'h0007_0002, 1'b0};
    vecs[8]  = '{1'b0, 4'hD, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b1, 4'hC, 32'h0000_1234, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 4'h2, 32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 4'h3, 32'h0,         32'h0,         1'b0};
    vecs[12] = '{1'b1, 4'h0, 32'h0000_0001, 32'h0,         1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; evt = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rdata_err", {rsp_rdata[30:0], rsp_err}, 32'd0);
    check("rst_cfg", 32'({c_wb, c_rtab, c_amo, c_plru, c_inh, c_waw, c_rtw, c_en, c_thr, c_sid}),
          32'h0000_0058);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, 8'h00, 0, rd, e);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      if (i == 3) begin
        check("cfg_enable", 32'(c_en), 32'd0);
        check("cfg_threshold", 32'(c_thr), 32'd7);
        check("cfg_sid", 32'(c_sid), 32'd5);
        check("cfg_bits", 32'({c_wb, c_rtab, c_amo, c_plru, c_inh, c_waw, c_rtw}), 32'h7F);
      end
    end

    // freeze / unfreeze on event 1
    evt = 8'h02; repeat (10) tick(); evt = 8'h00;
    rd_chk("cnt1_10", 4'h5, 32'd10);
    wr_reg(4'h2, 32'h1, 8'h00);
    evt = 8'h02; repeat (5) tick(); evt = 8'h00;
    rd_chk("cnt1_frozen", 4'h5, 32'd10);
    rd_chk("ctrl_freeze", 4'h2, 32'd1);
    wr_reg(4'h2, 32'h0, 8'h00);
    evt = 8'h02; tick(); evt = 8'h00;
    rd_chk("cnt1_11", 4'h5, 32'd11);

    // wrap, overflow W1C and load-vs-event priority on event 4
    wr_reg(4'h8, 32'hFFFF_FFFF, 8'h00);
    evt = 8'h10; tick(); evt = 8'h00;
    rd_chk("cnt4_wrap", 4'h8, 32'd0);
    rd_chk("ovf_set", 4'h3, 32'h10);
    wr_reg(4'h3, 32'h10, 8'h00);
    rd_chk("ovf_w1c", 4'h3, 32'h0);
    wr_reg(4'h8, 32'h55, 8'h10);
    rd_chk("cnt4_load_wins", 4'h8, 32'h55);
    wr_reg(4'h8, 32'hFFFF_FFFF, 8'h00);
    wr_reg(4'h3, 32'h10, 8'h10);
    rd_chk("ovf_set_wins", 4'h3, 32'h10);
    evt = 8'h04; tick(); evt = 8'h00;
    xfer(1'b0, 4'h6, 32'h0, 8'h04, 0, rd, e);
    check("cnt2_read_before_inc", rd, 32'd1);
    rd_chk("cnt2_after_inc", 4'h6, 32'd2);

    // back-pressure on the response
    xfer(1'b0, 4'h5, 32'h0, 8'h00, 3, rd, e);
    check("hold_read_value", rd, 32'd11);
    xfer(1'b0, 4'hD, 32'h0, 8'h00, 0, rd, e);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_err", 32'(e), 32'd1);

    // clear with all events pulsing in the same cycle
    evt = 8'hFF; repeat (3) tick();
    wr_reg(4'h2, 32'h2, 8'hFF);
    for (int k = 0; k < 8; k++) rd_chk($sformatf("clear_cnt%0d", k), 4'(4 + k), 32'h0);
    rd_chk("clear_ovf", 4'h3, 32'h0);
    rd_chk("clear_ctrl", 4'h2, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (!req_valid || m_acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 4'($urandom_range(0, 15));
        req_wdata = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2) : $urandom;
        if (req_we && req_addr == 4'h2 && $urandom_range(0, 3) != 0) req_wdata[1] = 1'b0;
      end
      evt       = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1; evt = 8'h00;
    tick(); tick();

    // reset while a response is pending
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h0;
    tick();
    req_valid = 1'b0;
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_cfg", 32'({c_en, c_thr}), 32'h0B);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    rd_chk("post_rst_cfg0", 4'h0, 32'h1);
    rd_chk("post_rst_cnt0", 4'h4, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
